// File: rtl/input_fetch_ctrl.sv
// Input activation buffer fetch controller: issues sequential buffer reads and streams the words out with a 2-entry skid FIFO.
// Optional macro INPUT_FETCH_STRIDE_EN adds a 'stride' port that sets the pointer increment per read.
module input_fetch_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
`ifdef INPUT_FETCH_STRIDE_EN
   input  logic [ADDR_WIDTH-1:0] stride,
`endif
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t                state, state_next;
   logic                  done_next;
   logic [ADDR_WIDTH-1:0] ptr, last_addr, step;
   logic [LEN_WIDTH-1:0]  issue_cnt, beat_cnt;
   logic                  inflight, inflight_last;
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic                  fifo_last [2];
   logic                  wr_idx, rd_idx;
   logic [1:0]            count;
   logic                  pop, pop_fifo, push, start_ok;
   logic [2:0]            occ;

`ifdef INPUT_FETCH_STRIDE_EN
   logic [ADDR_WIDTH-1:0] stride_q;
   assign step = stride_q;
`else
   assign step = ADDR_WIDTH'(1);
`endif

   // The word returning from the buffer this cycle counts as occupancy so it can bypass an empty FIFO.
   assign out_valid = (count != 2'd0) || inflight;
   assign pop       = out_valid && out_ready;
   assign pop_fifo  = pop && (count != 2'd0);
   assign push      = inflight && !(pop && (count == 2'd0));
   assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
   assign rd_en     = (state == FETCH) && (issue_cnt != '0) && (occ < 3'd2);
   assign rd_addr   = rd_en ? ptr : last_addr;
   assign busy      = (state != IDLE);
   assign start_ok  = (state == IDLE) && start && (length != '0);

   always_comb begin
      out_data = '0;
      out_last = 1'b0;
      if (count != 2'd0) begin
         out_data = fifo_data[rd_idx];
         out_last = fifo_last[rd_idx];
      end else if (inflight) begin
         out_data = rd_data;
         out_last = inflight_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (length != '0) state_next = FETCH;
               else              done_next  = 1'b1;
            end
         end
         FETCH: begin
            if (rd_en && (issue_cnt == LEN_WIDTH'(1))) state_next = DRAIN;
         end
         DRAIN: begin
            if (pop && (beat_cnt == LEN_WIDTH'(1))) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Transfer counters, address pointer and skid FIFO storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr           <= '0;
         last_addr     <= '0;
         issue_cnt     <= '0;
         beat_cnt      <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         wr_idx        <= 1'b0;
         rd_idx        <= 1'b0;
         count         <= 2'd0;
`ifdef INPUT_FETCH_STRIDE_EN
         stride_q      <= '0;
`endif
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         if (start_ok) begin
            ptr       <= base_addr;
            issue_cnt <= length;
            beat_cnt  <= length;
`ifdef INPUT_FETCH_STRIDE_EN
            stride_q  <= stride;
`endif
         end else begin
            if (rd_en) begin
               ptr       <= ptr + step;
               last_addr <= ptr;
               issue_cnt <= issue_cnt - LEN_WIDTH'(1);
            end
            if (pop) beat_cnt <= beat_cnt - LEN_WIDTH'(1);
         end
         inflight      <= rd_en;
         inflight_last <= rd_en && (issue_cnt == LEN_WIDTH'(1));
         if (push) begin
            fifo_data[wr_idx] <= rd_data;
            fifo_last[wr_idx] <= inflight_last;
            wr_idx            <= ~wr_idx;
         end
         if (pop_fifo) rd_idx <= ~rd_idx;
         count <= count + {1'b0, push} - {1'b0, pop_fifo};
      end
   end

endmodule

// File: tb/tb_input_fetch_ctrl.sv
// Self-checking bench for input_fetch_ctrl: transfer-level model plus directed literal checks.
// Define INPUT_FETCH_STRIDE_EN to also exercise the stride port.
module tb_input_fetch_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] base_addr = 8'd0;
   logic [7:0] stride = 8'd1;
   logic [8:0] length = 9'd0;
   logic       busy, done, rd_en, out_valid, out_last;
   logic [7:0] rd_addr, out_data;
   logic [7:0] rd_data = 8'd0;
   logic       out_ready = 1'b1;
   bit         ready_rand = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   input_fetch_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
`ifdef INPUT_FETCH_STRIDE_EN
      .stride(stride),
`endif
      .length(length), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [256];
   initial for (int a = 0; a < 256; a++) mem[a] = 8'(a);

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   always @(posedge clk) begin
      #1;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Transfer-level model: each accepted start queues its address and beat sequence.
   typedef struct { logic [7:0] data; bit last; } beat_t;
   beat_t      exp_beats [$];
   logic [7:0] exp_addrs [$];
   logic [7:0] addr_log [$];
   logic [7:0] data_log [$];
   bit         m_busy = 1'b0, m_done = 1'b0;
   int         outstanding = 0, cycle = 0;
   int         t_start = -1, t_first_rd = -1, t_first_valid = -1, t_last = -1, t_done = -1;
   bit         prev_stall = 1'b0, prev_last = 1'b0;
   logic [7:0] prev_data = 8'd0;
   bit         last_pop, nb, nd;
   beat_t      b;
   logic [7:0] a8;

   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         exp_beats.delete();
         exp_addrs.delete();
         m_busy = 1'b0; m_done = 1'b0; outstanding = 0; prev_stall = 1'b0;
      end else begin
         last_pop = 1'b0;
         checkOutput("busy", 32'(busy), 32'(m_busy));
         checkOutput("done", 32'(done), 32'(m_done));
         if (done && t_done < 0) t_done = cycle;
         if (rd_en) begin
            addr_log.push_back(rd_addr);
            if (t_first_rd < 0) t_first_rd = cycle;
            if (exp_addrs.size() == 0) checkOutput("rd_en_unexpected", 32'(rd_en), 32'd0);
            else checkOutput("rd_addr", 32'(rd_addr), 32'(exp_addrs.pop_front()));
            outstanding++;
         end
         if (out_valid && t_first_valid < 0) t_first_valid = cycle;
         if (prev_stall) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_data", 32'(out_data), 32'(prev_data));
            checkOutput("stall_last", 32'(out_last), 32'(prev_last));
         end
         if (out_valid && out_ready) begin
            data_log.push_back(out_data);
            if (exp_beats.size() == 0) checkOutput("beat_unexpected", 32'(out_valid), 32'd0);
            else begin
               b = exp_beats.pop_front();
               checkOutput("out_data", 32'(out_data), 32'(b.data));
               checkOutput("out_last", 32'(out_last), 32'(b.last));
               last_pop = b.last;
            end
            if (out_last) t_last = cycle;
            outstanding--;
         end
         checkOutput("outstanding_le2", 32'(outstanding <= 2), 32'd1);
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         nd = last_pop;
         nb = m_busy && !last_pop;
         if (start && !m_busy) begin
            if (length == 9'd0) nd = 1'b1;
            else begin
               nb = 1'b1;
               t_start = cycle;
               for (int i = 0; i < int'(length); i++) begin
                  a8 = 8'(int'(base_addr) + i * int'(stride));
                  exp_addrs.push_back(a8);
                  exp_beats.push_back('{data: mem[a8], last: (i == int'(length) - 1)});
               end
            end
         end
         m_busy = nb;
         m_done = nd;
      end
   end

   task automatic applyStimulus(input logic [7:0] b_addr, input logic [8:0] len, input logic [7:0] s);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b_addr; length = len; stride = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input int max_cycles);
      bit seen = 1'b0;
      for (int n = 0; n < max_cycles && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) checkOutput("done_timeout", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic clearLogs();
      addr_log.delete();
      data_log.delete();
      t_start = -1; t_first_rd = -1; t_first_valid = -1; t_last = -1; t_done = -1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
      checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_out_last"}, 32'(out_last), 32'd0);
      checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
   endtask

   task automatic checkLog(input string tag, input logic [7:0] log_q [$], input logic [7:0] exp_q [$]);
      checkOutput({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         checkOutput($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      logic [7:0] seq [$];
      bit reached;
      #2;
      checkResetOutputs("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] basic stream");
      clearLogs();
      applyStimulus(8'h10, 9'd4, 8'd1);
      waitDone(20);
      seq = '{8'h10, 8'h11, 8'h12, 8'h13};
      checkLog("basic_addr", addr_log, seq);
      checkLog("basic_data", data_log, seq);
      checkOutput("lat_first_rd", 32'(t_first_rd - t_start), 32'd1);
      checkOutput("lat_first_valid", 32'(t_first_valid - t_start), 32'd2);
      checkOutput("lat_last", 32'(t_last - t_start), 32'd5);
      checkOutput("lat_done", 32'(t_done - t_start), 32'd6);
      @(negedge clk);
      checkOutput("basic_busy_after", 32'(busy), 32'd0);

      $display("[TB] backpressure");
      clearLogs();
      ready_rand = 1'b1;
      applyStimulus(8'h00, 9'd8, 8'd1);
      waitDone(300);
      ready_rand = 1'b0;
      seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      checkLog("bp_data", data_log, seq);

      $display("[TB] wrap");
      clearLogs();
      applyStimulus(8'hFE, 9'd4, 8'd1);
      waitDone(20);
      seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      checkLog("wrap_addr", addr_log, seq);
      checkLog("wrap_data", data_log, seq);

      $display("[TB] zero length and ignored start");
      clearLogs();
      applyStimulus(8'h30, 9'd0, 8'd1);
      @(negedge clk);
      checkOutput("zl_done", 32'(done), 32'd1);
      checkOutput("zl_busy", 32'(busy), 32'd0);
      checkOutput("zl_rd_en", 32'(rd_en), 32'd0);
      @(posedge clk); #1;
      checkOutput("zl_no_reads", 32'(addr_log.size()), 32'd0);
      applyStimulus(8'h50, 9'd6, 8'd1);
      applyStimulus(8'h80, 9'd3, 8'd1);
      waitDone(40);
      repeat (5) @(posedge clk);
      seq = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
      checkLog("ign_data", data_log, seq);

      $display("[TB] reset mid-transfer");
      clearLogs();
      applyStimulus(8'h20, 9'd10, 8'd1);
      reached = 1'b0;
      for (int n = 0; n < 50 && !reached; n++) begin
         @(negedge clk);
         if (data_log.size() >= 3) reached = 1'b1;
      end
      checkOutput("mid_reached_beat3", 32'(reached), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midrst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clearLogs();
      applyStimulus(8'h40, 9'd2, 8'd1);
      waitDone(20);
      repeat (3) @(posedge clk);
      seq = '{8'h40, 8'h41};
      checkLog("post_rst_data", data_log, seq);

`ifdef INPUT_FETCH_STRIDE_EN
      $display("[TB] stride");
      clearLogs();
      applyStimulus(8'h00, 9'd4, 8'd3);
      waitDone(20);
      seq = '{8'h00, 8'h03, 8'h06, 8'h09};
      checkLog("stride_addr", addr_log, seq);
      clearLogs();
      applyStimulus(8'h22, 9'd3, 8'd0);
      waitDone(20);
      seq = '{8'h22, 8'h22, 8'h22};
      checkLog("stride0_data", data_log, seq);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
